// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding SRAM request, a one-entry output buffer,
// a one-word hold register for back-pressure and prioritized redirects.
module inst_fetch (
    input  logic        clk,
    input  logic        rstn,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        pD_allowin,
    output logic        FpD_valid,
    output logic [74:0] FpD_BUS,
    input  logic [32:0] predict_BUS,
    input  logic        predict_error,
    input  logic [31:0] br_target,
    input  logic        ertn_flush,
    input  logic [31:0] era,
    input  logic        ex_en,
    input  logic [31:0] eentry
);
    localparam logic [31:0] ResetPc   = 32'h1C00_0000;
    localparam logic [7:0]  EcodeAdef = 8'h08;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StExc} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_q, hold_d;
    logic [74:0] buf_q, buf_d;
    logic        buf_valid_q, buf_valid_d;
    logic        cancel_q, cancel_d;

    logic        predict_fire, redirect, buf_free, pc_misaligned, req_accept;
    logic        load_fetch, load_hold, load_exc, capture_hold;
    logic [31:0] redirect_pc;

    // Only exception entry and return may pull the stage out of the exception state.
    always_comb begin
        predict_fire = predict_BUS[32] & pD_allowin;
        redirect     = ex_en | ertn_flush
                     | ((predict_error | predict_fire) & (state_q != StExc));
        if (ex_en) begin
            redirect_pc = eentry;
        end else if (ertn_flush) begin
            redirect_pc = era;
        end else if (predict_error) begin
            redirect_pc = br_target;
        end else begin
            redirect_pc = predict_BUS[31:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_fetch   = 1'b0;
        load_hold    = 1'b0;
        load_exc     = 1'b0;
        capture_hold = 1'b0;
        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (pc_misaligned) begin
                    if (buf_free) begin
                        load_exc = 1'b1;
                        state_d  = StExc;
                    end
                end else if (req_accept) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (inst_sram_data_ok) begin
                    if (buf_free) begin
                        load_fetch = 1'b1;
                        state_d    = StReq;
                    end else begin
                        capture_hold = 1'b1;
                        state_d      = StHold;
                    end
                end
            end
            StHold: begin
                if (buf_free) begin
                    load_hold = 1'b1;
                    state_d   = StReq;
                end
            end
            StExc:   state_d = StExc;
            default: state_d = StIdle;
        endcase
        if (redirect) begin
            state_d = StReq;
        end
    end

    always_comb begin
        FpD_valid     = buf_valid_q & ~redirect;
        pc_misaligned = fetch_pc_q[1:0] != 2'b00;
        buf_free      = ~buf_valid_q | (FpD_valid & pD_allowin);
        inst_sram_req = (state_q == StReq) & ~cancel_q & ~pc_misaligned & buf_free;
        req_accept    = inst_sram_req & inst_sram_addr_ok;
    end

    assign inst_sram_addr = fetch_pc_q;
    assign FpD_BUS        = buf_q;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        hold_d      = hold_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q & ~(FpD_valid & pD_allowin);
        cancel_d    = cancel_q & ~inst_sram_data_ok;
        if (capture_hold) begin
            hold_d = inst_sram_rdata;
        end
        if (load_fetch) begin
            buf_d = {fetch_pc_q, inst_sram_rdata, 1'b1, 1'b0, 8'h00, 1'b0};
        end
        if (load_hold) begin
            buf_d = {fetch_pc_q, hold_q, 1'b1, 1'b0, 8'h00, 1'b0};
        end
        if (load_exc) begin
            buf_d = {fetch_pc_q, 32'h0, 1'b1, 1'b1, EcodeAdef, 1'b0};
        end
        if (load_fetch | load_hold | load_exc) begin
            buf_valid_d = 1'b1;
        end
        if (load_fetch | load_hold) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        // An accepted request whose data is still to come must be dropped on return.
        if (redirect) begin
            fetch_pc_d  = redirect_pc;
            buf_valid_d = 1'b0;
            cancel_d    = (cancel_q & ~inst_sram_data_ok)
                        | ((state_q == StWait) & ~inst_sram_data_ok)
                        | req_accept;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q  <= ResetPc;
            hold_q      <= 32'h0;
            buf_q       <= 75'h0;
            buf_valid_q <= 1'b0;
            cancel_q    <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            hold_q      <= hold_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            cancel_q    <= cancel_d;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: an SRAM responder plus a program-flow model that
// predicts the delivered instruction stream and the fetch addresses.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        allowin = 1'b0;
    logic        fvalid;
    logic [74:0] fbus;
    logic [32:0] pbus = 33'h0;
    logic        perr = 1'b0, ertn = 1'b0, exen = 1'b0;
    logic [31:0] brt = 32'h0, era_v = 32'h0, eentry = 32'h0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk               (clk),
        .rstn              (rstn),
        .inst_sram_req     (req),
        .inst_sram_addr    (addr),
        .inst_sram_addr_ok (addr_ok),
        .inst_sram_data_ok (data_ok),
        .inst_sram_rdata   (rdata),
        .pD_allowin        (allowin),
        .FpD_valid         (fvalid),
        .FpD_BUS           (fbus),
        .predict_BUS       (pbus),
        .predict_error     (perr),
        .br_target         (brt),
        .ertn_flush        (ertn),
        .era               (era_v),
        .ex_en             (exen),
        .eentry            (eentry)
    );

    int errs = 0, checks = 0;

    task automatic check(input bit ok, input string nm, input logic [74:0] act,
                         input logic [74:0] exp);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] rnd_tgt(input int unsigned mis);
        logic [31:0] t;
        t = 32'h1C00_0000 + ($urandom_range(1023) << 2);
        if ($urandom_range(31) == 0) t = 32'hFFFF_FFF0;
        if (mis != 0 && $urandom_range(mis - 1) == 0) t = t | $urandom_range(3, 1);
        return t;
    endfunction

    // Knobs and one-shot directed redirect requests.
    int unsigned ok_pct = 100, lat_max = 0, allow_pct = 100;
    bit          rand_redir = 0;
    bit          d_ex = 0, d_ertn = 0, d_perr = 0, d_ptk = 0;
    logic [31:0] d_eentry = 0, d_era = 0, d_brt = 0, d_ptgt = 0;

    // SRAM responder state and program-flow model.
    bit          pending = 0;
    logic [31:0] pend_addr = 0;
    int unsigned lat_cnt = 0;
    logic [31:0] ep = 32'h1C00_0000;
    bit          prev_stall = 0;
    logic [74:0] prev_bus = 0, last_bus = 0, exp_bus;
    logic [31:0] req_log[$], cons_log[$];
    logic [31:0] exp_addr, tgt;
    bit          redir, cons;
    int          gap = 0, req_cycles = 0;

    task automatic step();
        @(posedge clk);
        #1;
        addr_ok = ($urandom_range(99) < ok_pct);
        allowin = ($urandom_range(99) < allow_pct);
        data_ok = 1'b0;
        rdata   = $urandom;
        if (rstn && pending) begin
            if (lat_cnt == 0) begin
                data_ok = 1'b1;
                rdata   = mem(pend_addr);
            end else begin
                lat_cnt--;
            end
        end
        exen = d_ex; ertn = d_ertn; perr = d_perr; pbus = {d_ptk, d_ptgt};
        eentry = d_eentry; era_v = d_era; brt = d_brt;
        if (rand_redir) begin
            exen    = ($urandom_range(999) < 15);
            ertn    = ($urandom_range(999) < 15);
            // Branch redirects only make sense while the flow is not in an exception.
            perr    = (ep[1:0] == 2'b00) && ($urandom_range(999) < 30);
            pbus[32] = (ep[1:0] == 2'b00) && ($urandom_range(999) < 40);
            eentry  = rnd_tgt(8);
            era_v   = rnd_tgt(0);
            brt     = rnd_tgt(16);
            pbus[31:0] = rnd_tgt(0);
        end
        d_ex = 0; d_ertn = 0; d_perr = 0; d_ptk = 0;
    endtask

    task automatic wait_pending(input string nm);
        int n;
        n = 0;
        do begin
            step();
            @(negedge clk);
            #1;
            n++;
        end while (!(pending && lat_cnt > 0) && n < 100);
        check(n < 100, nm, n, 100);
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            pending = 0; ep = 32'h1C00_0000; prev_stall = 0; gap = 0;
        end else begin
            redir = exen | ertn | perr | (pbus[32] & allowin);
            tgt   = exen ? eentry : ertn ? era_v : perr ? brt : pbus[31:0];
            cons  = fvalid & allowin;
            if (redir) check(fvalid == 1'b0, "valid_on_redirect", fvalid, 0);
            if (prev_stall && !redir)
                check(fvalid && fbus == prev_bus, "stall_hold", fbus, prev_bus);
            if (req) begin
                check(!pending, "one_outstanding", pend_addr, 0);
                check(addr[1:0] == 2'b00, "req_aligned", addr, 0);
                if (!redir) begin
                    exp_addr = fvalid ? fbus[74:43] + 32'd4 : ep;
                    check(addr == exp_addr, "req_addr", addr, exp_addr);
                    check(!fvalid || allowin, "req_while_full", fvalid, 0);
                    req_cycles++;
                    if (addr_ok) req_log.push_back(addr);
                end
            end
            if (cons) begin
                if (ep[1:0] != 2'b00) exp_bus = {ep, 32'h0, 1'b1, 1'b1, 8'h08, 1'b0};
                else                  exp_bus = {ep, mem(ep), 1'b1, 1'b0, 8'h00, 1'b0};
                check(fbus == exp_bus, "fetch_word", fbus, exp_bus);
                cons_log.push_back(fbus[74:43]);
                last_bus = fbus;
                ep = ep + 32'd4;
                gap = 0;
            end else begin
                gap++;
            end
            if (gap > 1000) begin
                check(1'b0, "progress_timeout", gap, 1000);
                gap = 0;
            end
            if (redir) ep = tgt;
            prev_stall = fvalid & ~allowin & ~redir;
            prev_bus   = fbus;
            if (data_ok) pending = 0;
            if (req && addr_ok) begin
                pending   = 1;
                pend_addr = addr;
                lat_cnt   = $urandom_range(lat_max);
            end
        end
    end

    initial begin
        int n0, m0, r1, c0;
        #12;
        check(req == 1'b0, "rst_req", req, 0);
        check(fvalid == 1'b0, "rst_valid", fvalid, 0);
        check(addr == 32'h1C00_0000, "rst_addr", addr, 32'h1C00_0000);
        check(fbus == 75'h0, "rst_bus", fbus, 0);
        step();
        rstn = 1'b1;
        repeat (20) step();
        for (int i = 0; i < 3; i++)
            check(cons_log.size() > i && cons_log[i] == 32'h1C00_0000 + 32'(4 * i),
                  "first_pcs", cons_log.size() > i ? cons_log[i] : 0,
                  32'h1C00_0000 + 32'(4 * i));

        // Back-pressure with buffer and hold full.
        allow_pct = 0;
        repeat (3) step();
        r1 = req_cycles;
        repeat (5) step();
        check(req_cycles == r1, "stall_no_req", req_cycles, r1);
        allow_pct = 100;
        repeat (10) step();

        // Mispredict while a request is outstanding.
        lat_max = 3;
        wait_pending("wait_for_perr");
        n0 = req_log.size(); m0 = cons_log.size();
        d_perr = 1; d_brt = 32'h1C00_0100;
        step();
        repeat (15) step();
        check(req_log.size() > n0 && req_log[n0] == 32'h1C00_0100, "perr_req",
              req_log.size() > n0 ? req_log[n0] : 0, 32'h1C00_0100);
        check(cons_log.size() > m0 && cons_log[m0] == 32'h1C00_0100, "perr_pc",
              cons_log.size() > m0 ? cons_log[m0] : 0, 32'h1C00_0100);

        // Taken prediction from preDecode.
        lat_max = 0;
        repeat (5) step();
        @(negedge clk); #1;
        n0 = req_log.size();
        d_ptk = 1; d_ptgt = 32'h1C00_0040;
        step();
        @(negedge clk);
        check(fvalid == 1'b0, "predict_valid_low", fvalid, 0);
        repeat (10) step();
        check(req_log.size() > n0 && req_log[n0] == 32'h1C00_0040, "predict_req",
              req_log.size() > n0 ? req_log[n0] : 0, 32'h1C00_0040);

        // Exception to a misaligned handler, then return.
        @(negedge clk); #1;
        n0 = req_log.size();
        d_ex = 1; d_eentry = 32'h1C00_8002;
        step();
        repeat (10) step();
        check(req_log.size() == n0, "exc_no_req", req_log.size(), n0);
        check(last_bus[74:43] == 32'h1C00_8002, "exc_pc", last_bus[74:43], 32'h1C00_8002);
        check(last_bus[9] == 1'b1, "exc_exF", last_bus[9], 1);
        check(last_bus[8:1] == 8'h08, "exc_ecode", last_bus[8:1], 8'h08);
        d_ertn = 1; d_era = 32'h1C00_0010;
        step();
        repeat (10) step();
        check(req_log.size() > n0 && req_log[n0] == 32'h1C00_0010, "ertn_req",
              req_log.size() > n0 ? req_log[n0] : 0, 32'h1C00_0010);

        // Exception beats mispredict in the same cycle.
        @(negedge clk); #1;
        n0 = req_log.size();
        d_ex = 1; d_eentry = 32'h1C00_0200; d_perr = 1; d_brt = 32'h1C00_0300;
        step();
        repeat (10) step();
        check(req_log.size() > n0 && req_log[n0] == 32'h1C00_0200, "prio_req",
              req_log.size() > n0 ? req_log[n0] : 0, 32'h1C00_0200);

        // Asynchronous reset while waiting for data.
        lat_max = 3;
        wait_pending("wait_for_rst");
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check(req == 1'b0, "midrst_req", req, 0);
        check(fvalid == 1'b0, "midrst_valid", fvalid, 0);
        check(addr == 32'h1C00_0000, "midrst_addr", addr, 32'h1C00_0000);
        check(fbus == 75'h0, "midrst_bus", fbus, 0);
        n0 = req_log.size();
        step();
        step();
        rstn = 1'b1;
        repeat (10) step();
        check(req_log.size() > n0 && req_log[n0] == 32'h1C00_0000, "rst_restart",
              req_log.size() > n0 ? req_log[n0] : 0, 32'h1C00_0000);

        // Randomized traffic and redirects.
        c0 = cons_log.size();
        rand_redir = 1;
        for (int b = 0; b < 40; b++) begin
            ok_pct    = $urandom_range(100, 30);
            lat_max   = $urandom_range(4, 0);
            allow_pct = $urandom_range(100, 20);
            repeat (200) step();
        end
        rand_redir = 0;
        check(cons_log.size() > c0 + 100, "random_progress", cons_log.size(), c0 + 100);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
